// File: rtl/button_bounce_gen_if.sv
// button_bounce_gen_if: press/abort request side and emulated button outputs
interface button_bounce_gen_if #(
    parameter int HOLD_W = 16
);
    logic              press_req;
    logic              abort;
    logic [HOLD_W-1:0] hold_cycles;
    logic              bounce_out;
    logic              busy;
    logic              done;
    logic              ignored_req;
    modport master (output press_req, abort, hold_cycles, input bounce_out, busy, done, ignored_req);
    modport slave (input press_req, abort, hold_cycles, output bounce_out, busy, done, ignored_req);
endinterface

// File: rtl/button_bounce_gen.sv
// button_bounce_gen: drives a button line with pseudo-random bounce around a stable hold
module button_bounce_gen #(
    parameter int         BOUNCES   = 3,
    parameter int         GLITCH_W  = 2,
    parameter int         HOLD_W    = 16,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input logic                clk,
    input logic                resetn,
    button_bounce_gen_if.slave bus
);
    localparam logic [7:0] SEED = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
    localparam int GI_W = (BOUNCES > 0) ? $clog2(2 * BOUNCES + 1) : 1;
    localparam logic [GI_W-1:0] GI_INIT = GI_W'(2 * BOUNCES);
    typedef enum logic [1:0] {IDLE, PRESS_BOUNCE, HOLD, RELEASE_BOUNCE} state_t;
    state_t            state;
    logic [7:0]        lfsr;
    logic [7:0]        lfsr_next;
    logic [GLITCH_W:0] seg_cnt;
    logic [GLITCH_W:0] seg_len;
    logic [GI_W-1:0]   glitch_idx;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_lat;
    logic [HOLD_W-1:0] hold_in;
    assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    assign seg_len   = {1'b0, lfsr[GLITCH_W-1:0]} + 1'b1;
    assign hold_in   = (bus.hold_cycles == '0) ? HOLD_W'(1) : bus.hold_cycles;
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state           <= IDLE;
            lfsr            <= SEED;
            seg_cnt         <= '0;
            glitch_idx      <= '0;
            hold_cnt        <= '0;
            hold_lat        <= '0;
            bus.bounce_out  <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.ignored_req <= 1'b0;
        end else begin
            bus.done        <= 1'b0;
            bus.ignored_req <= bus.press_req && state != IDLE;
            if (state != IDLE && bus.abort) begin
                state          <= IDLE;
                bus.bounce_out <= 1'b0;
                bus.busy       <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        bus.bounce_out <= 1'b0;
                        if (bus.press_req && !bus.abort) begin
                            bus.busy       <= 1'b1;
                            bus.bounce_out <= 1'b1;
                            hold_lat       <= hold_in;
                            hold_cnt       <= hold_in;
                            if (BOUNCES > 0) begin
                                state      <= PRESS_BOUNCE;
                                seg_cnt    <= seg_len;
                                lfsr       <= lfsr_next;
                                glitch_idx <= GI_INIT;
                            end else begin
                                state <= HOLD;
                            end
                        end
                    end
                    PRESS_BOUNCE, RELEASE_BOUNCE: begin
                        if (seg_cnt == (GLITCH_W+1)'(1)) begin
                            glitch_idx <= glitch_idx - 1'b1;
                            if (glitch_idx == GI_W'(1)) begin
                                bus.bounce_out <= state == PRESS_BOUNCE;
                                if (state == PRESS_BOUNCE) begin
                                    state    <= HOLD;
                                    hold_cnt <= hold_lat;
                                end else begin
                                    state    <= IDLE;
                                    bus.done <= 1'b1;
                                    bus.busy <= 1'b0;
                                end
                            end else begin
                                bus.bounce_out <= !bus.bounce_out;
                                seg_cnt        <= seg_len;
                                lfsr           <= lfsr_next;
                            end
                        end else begin
                            seg_cnt <= seg_cnt - 1'b1;
                        end
                    end
                    HOLD: begin
                        if (hold_cnt == HOLD_W'(1)) begin
                            bus.bounce_out <= 1'b0;
                            if (BOUNCES > 0) begin
                                state      <= RELEASE_BOUNCE;
                                seg_cnt    <= seg_len;
                                lfsr       <= lfsr_next;
                                glitch_idx <= GI_INIT;
                            end else begin
                                state    <= IDLE;
                                bus.done <= 1'b1;
                                bus.busy <= 1'b0;
                            end
                        end else begin
                            hold_cnt <= hold_cnt - 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_button_bounce_gen.sv
// tb_button_bounce_gen: directed checks of clean edges, bounce sequences, abort, reset and a debouncer loop
module tb_button_bounce_gen;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;

    button_bounce_gen_if #(.HOLD_W(16)) bus0 ();
    button_bounce_gen_if #(.HOLD_W(16)) bus3 ();
    button_bounce_gen_if #(.HOLD_W(16)) bus1 ();
    button_bounce_gen #(.BOUNCES(0), .GLITCH_W(2), .HOLD_W(16)) u0 (.clk(clk), .resetn(resetn), .bus(bus0));
    button_bounce_gen #(.BOUNCES(3), .GLITCH_W(2), .HOLD_W(16)) u3 (.clk(clk), .resetn(resetn), .bus(bus3));
    button_bounce_gen #(.BOUNCES(3), .GLITCH_W(1), .HOLD_W(16)) u1 (.clk(clk), .resetn(resetn), .bus(bus1));

    // seed 8'hA5 run lengths: six press glitches, 20-cycle hold, six release glitches
    int exp_seq [13] = '{2, 3, 2, 3, 1, 2, 20, 4, 4, 3, 2, 4, 4};
    int exp_next [7] = '{3, 2, 4, 3, 1, 2, 20};

    logic       db_level = 1'b0;
    logic [3:0] db_cnt = 4'd0;
    int         db_pulses = 0;
    always @(posedge clk) begin
        if (!resetn) begin
            db_level <= 1'b0;
            db_cnt   <= 4'd0;
        end else if (bus1.bounce_out == db_level) begin
            db_cnt <= 4'd0;
        end else if (db_cnt == 4'd9) begin
            db_level <= bus1.bounce_out;
            db_cnt   <= 4'd0;
            if (bus1.bounce_out) db_pulses <= db_pulses + 1;
        end else begin
            db_cnt <= db_cnt + 4'd1;
        end
    end

    int   runs[$];
    int   rises, done_cnt, ign_cnt, n_samp;
    logic timed_out, first_busy, end_bounce;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // caller raises bus3.press_req; records run lengths of bounce_out until busy drops
    task automatic record3(input int press_at, input int abort_at);
        logic prev;
        int   len;
        runs.delete();
        rises = 0; done_cnt = 0; ign_cnt = 0; n_samp = -1;
        timed_out = 1'b1; prev = 1'b0; len = 0; end_bounce = 1'bx;
        tick;
        bus3.press_req = 1'b0;
        first_busy = bus3.busy;
        for (int c = 0; c < 400; c++) begin
            done_cnt += int'(bus3.done);
            ign_cnt += int'(bus3.ignored_req);
            if (bus3.bounce_out !== prev) begin
                if (len > 0) runs.push_back(len);
                rises += int'(bus3.bounce_out);
                prev = bus3.bounce_out;
                len = 1;
            end else begin
                len++;
            end
            if (!bus3.busy) begin
                timed_out = 1'b0;
                n_samp = c;
                end_bounce = bus3.bounce_out;
                break;
            end
            bus3.press_req = (c == press_at);
            bus3.abort = (c == abort_at);
            tick;
        end
        bus3.press_req = 1'b0;
        bus3.abort = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) tick;
        checks++; if ({bus0.bounce_out, bus0.busy, bus0.done, bus0.ignored_req} !== 4'b0) begin errors++; $display("FAIL reset_u0: got %b expected 0000", {bus0.bounce_out, bus0.busy, bus0.done, bus0.ignored_req}); end
        checks++; if ({bus3.bounce_out, bus3.busy, bus3.done, bus3.ignored_req} !== 4'b0) begin errors++; $display("FAIL reset_u3: got %b expected 0000", {bus3.bounce_out, bus3.busy, bus3.done, bus3.ignored_req}); end
        checks++; if ({bus1.bounce_out, bus1.busy, bus1.done, bus1.ignored_req} !== 4'b0) begin errors++; $display("FAIL reset_u1: got %b expected 0000", {bus1.bounce_out, bus1.busy, bus1.done, bus1.ignored_req}); end
        resetn = 1'b1;
        tick;
    endtask

    task automatic test_clean_edge(input logic [15:0] hold, input int exp_high);
        int   high;
        logic fell;
        bus0.hold_cycles = hold;
        bus0.press_req = 1'b1;
        tick;
        bus0.press_req = 1'b0;
        high = 0; fell = 1'b0;
        checks++; if (bus0.busy !== 1'b1) begin errors++; $display("FAIL clean_busy_start: got %b expected 1", bus0.busy); end
        for (int c = 0; c < 50 && !fell; c++) begin
            if (bus0.bounce_out) begin high++; tick; end
            else fell = 1'b1;
        end
        checks++; if (fell !== 1'b1) begin errors++; $display("FAIL clean_timeout: got %b expected 1", fell); end
        checks++; if (high !== exp_high) begin errors++; $display("FAIL clean_high_len hold=%0d: got %0d expected %0d", hold, high, exp_high); end
        checks++; if (bus0.done !== 1'b1) begin errors++; $display("FAIL clean_done_at_fall: got %b expected 1", bus0.done); end
        checks++; if (bus0.busy !== 1'b0) begin errors++; $display("FAIL clean_busy_at_fall: got %b expected 0", bus0.busy); end
        tick;
        checks++; if (bus0.done !== 1'b0) begin errors++; $display("FAIL clean_done_one_cycle: got %b expected 0", bus0.done); end
    endtask

    task automatic test_bounce_sequence;
        bus3.hold_cycles = 16'd20;
        bus3.press_req = 1'b1;
        record3(-1, -1);
        checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL seq_timeout: got %b expected 0", timed_out); end
        checks++; if (runs.size() !== 13) begin errors++; $display("FAIL seq_run_count: got %0d expected 13", runs.size()); end
        for (int i = 0; i < 13; i++) begin
            checks++; if (((i < runs.size()) ? runs[i] : -1) !== exp_seq[i]) begin errors++; $display("FAIL seq_run[%0d]: got %0d expected %0d", i, (i < runs.size()) ? runs[i] : -1, exp_seq[i]); end
        end
        checks++; if (rises !== 7) begin errors++; $display("FAIL seq_rises: got %0d expected 7", rises); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL seq_done: got %0d expected 1", done_cnt); end
        checks++; if (end_bounce !== 1'b0) begin errors++; $display("FAIL seq_end_level: got %b expected 0", end_bounce); end
    endtask

    task automatic test_ignored_req;
        int busy_n = 0;
        bus3.hold_cycles = 16'd20;
        bus3.press_req = 1'b1;
        record3(20, -1);
        checks++; if (runs.size() !== 13) begin errors++; $display("FAIL ign_run_count: got %0d expected 13", runs.size()); end
        for (int i = 0; i < runs.size(); i++) begin
            if (i == 6) begin
                checks++; if (runs[i] !== 20) begin errors++; $display("FAIL ign_hold_len: got %0d expected 20", runs[i]); end
            end else begin
                checks++; if (runs[i] < 1 || runs[i] > 4) begin errors++; $display("FAIL ign_seg_bound[%0d]: got %0d expected 1..4", i, runs[i]); end
            end
        end
        checks++; if (ign_cnt !== 1) begin errors++; $display("FAIL ign_pulses: got %0d expected 1", ign_cnt); end
        checks++; if (rises !== 7) begin errors++; $display("FAIL ign_rises: got %0d expected 7", rises); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL ign_done: got %0d expected 1", done_cnt); end
        repeat (6) begin tick; busy_n += int'(bus3.busy); end
        checks++; if (busy_n !== 0) begin errors++; $display("FAIL ign_no_second_txn: got %0d busy cycles expected 0", busy_n); end
    endtask

    task automatic test_abort;
        int done_n = 0;
        bus3.hold_cycles = 16'd20;
        bus3.press_req = 1'b1;
        record3(-1, 1);
        checks++; if (n_samp !== 2) begin errors++; $display("FAIL abort_idle_cycle: got %0d expected 2", n_samp); end
        checks++; if (end_bounce !== 1'b0) begin errors++; $display("FAIL abort_level: got %b expected 0", end_bounce); end
        checks++; if (done_cnt !== 0) begin errors++; $display("FAIL abort_done: got %0d expected 0", done_cnt); end
        repeat (5) begin tick; done_n += int'(bus3.done); end
        checks++; if (done_n !== 0) begin errors++; $display("FAIL abort_late_done: got %0d expected 0", done_n); end
        bus3.press_req = 1'b1;
        record3(-1, -1);
        checks++; if (first_busy !== 1'b1) begin errors++; $display("FAIL abort_reaccept: got %b expected 1", first_busy); end
        checks++; if (rises !== 7) begin errors++; $display("FAIL abort_next_rises: got %0d expected 7", rises); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL abort_next_done: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_reset_repeat;
        bus3.hold_cycles = 16'd100;
        bus3.press_req = 1'b1;
        tick;
        bus3.press_req = 1'b0;
        repeat (40) tick;
        checks++; if ({bus3.bounce_out, bus3.busy} !== 2'b11) begin errors++; $display("FAIL rr_in_hold: got %b expected 11", {bus3.bounce_out, bus3.busy}); end
        resetn = 1'b0;
        tick;
        checks++; if ({bus3.bounce_out, bus3.busy, bus3.done, bus3.ignored_req} !== 4'b0) begin errors++; $display("FAIL rr_reset_outputs: got %b expected 0000", {bus3.bounce_out, bus3.busy, bus3.done, bus3.ignored_req}); end
        resetn = 1'b1;
        tick;
        bus3.hold_cycles = 16'd20;
        bus3.press_req = 1'b1;
        record3(-1, -1);
        checks++; if (runs.size() !== 13) begin errors++; $display("FAIL rr_run_count: got %0d expected 13", runs.size()); end
        for (int i = 0; i < 13; i++) begin
            checks++; if (((i < runs.size()) ? runs[i] : -1) !== exp_seq[i]) begin errors++; $display("FAIL rr_run[%0d]: got %0d expected %0d", i, (i < runs.size()) ? runs[i] : -1, exp_seq[i]); end
        end
        checks++; if (bus3.done !== 1'b1) begin errors++; $display("FAIL rr_done_edge: got %b expected 1", bus3.done); end
        bus3.press_req = 1'b1;
        record3(-1, -1);
        checks++; if (first_busy !== 1'b1) begin errors++; $display("FAIL rr_back_to_back_accept: got %b expected 1", first_busy); end
        for (int i = 0; i < 7; i++) begin
            checks++; if (((i < runs.size()) ? runs[i] : -1) !== exp_next[i]) begin errors++; $display("FAIL rr_next_run[%0d]: got %0d expected %0d", i, (i < runs.size()) ? runs[i] : -1, exp_next[i]); end
        end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL rr_next_done: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_debounce_loop;
        int   p0;
        logic ended;
        bus1.hold_cycles = 16'd30;
        for (int t = 0; t < 2; t++) begin
            p0 = db_pulses;
            bus1.press_req = 1'b1;
            tick;
            bus1.press_req = 1'b0;
            ended = 1'b0;
            for (int c = 0; c < 300 && !ended; c++) begin
                if (!bus1.busy) ended = 1'b1;
                else tick;
            end
            repeat (15) tick;
            checks++; if (ended !== 1'b1) begin errors++; $display("FAIL db_timeout[%0d]: got %b expected 1", t, ended); end
            checks++; if (db_pulses - p0 !== 1) begin errors++; $display("FAIL db_pulses[%0d]: got %0d expected 1", t, db_pulses - p0); end
        end
    endtask

    initial begin
        bus0.press_req = 1'b0; bus0.abort = 1'b0; bus0.hold_cycles = '0;
        bus3.press_req = 1'b0; bus3.abort = 1'b0; bus3.hold_cycles = '0;
        bus1.press_req = 1'b0; bus1.abort = 1'b0; bus1.hold_cycles = '0;
        test_reset;
        test_clean_edge(16'd5, 5);
        test_clean_edge(16'd0, 1);
        test_bounce_sequence;
        test_ignored_req;
        test_abort;
        test_reset_repeat;
        test_debounce_loop;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
